// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding and the default iteration count.
package mdu_pkg;

   localparam int ITER_DEF = 32;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/mdu_hilo_if.sv
// EX-stage request/result bundle between the pipeline and the HI/LO unit.
// The pipeline side (master) drives the request; the unit (slave) returns
// busy and the architectural HI/LO values.
interface mdu_hilo_if;
   logic        start;
   logic [2:0]  MDUCode;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, MDUCode, A, B, flush,
                   input  busy, HI, LO);
   modport slave  (input  start, MDUCode, A, B, flush,
                   output busy, HI, LO);
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// remainder, try subtracting the divisor, keep the difference only when it
// does not borrow, and shift the resulting quotient bit in.
module mdu_div_step
   import mdu_pkg::*;
(
   input  logic [31:0] rem,
   input  logic [31:0] quo,
   input  logic [31:0] divisor,
   output logic [31:0] rem_next,
   output logic [31:0] quo_next
);

   logic [32:0] shifted;
   logic [33:0] trial;

   // Trial subtract; trial[33] is the borrow out of the 33-bit subtract.
   always_comb begin
      shifted  = {rem, quo[31]};
      trial    = {1'b0, shifted} - {2'b00, divisor};
      rem_next = trial[33] ? shifted[31:0] : trial[31:0];
      quo_next = {quo[30:0], ~trial[33]};
   end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// Multiply is shift-add, divide is restoring; both take ITER RUN cycles plus
// one FIX cycle for sign correction and writeback, holding busy throughout.
// Optional build macro MDU_FAST_MUL_EN: MULT/MULTU complete combinationally
// at the request edge without raising busy; divide stays iterative.
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int          ITER    = ITER_DEF,
   parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
)
(
   input  logic       clk,
   input  logic       rst_n,
   mdu_hilo_if.slave  bus
);

   mdu_state_t  state;
   logic [5:0]  cnt;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   logic [31:0] acc_hi;
   logic [31:0] acc_lo;
   logic [31:0] opnd_b;
   logic        op_div;
   logic        neg_prod;
   logic        neg_quo;
   logic        neg_rem;
   logic        div0;

   logic        is_mul;
   logic        is_div;
   logic        is_md;
   logic        signed_op;
   logic        load;
   logic [32:0] mul_sum;
   logic [31:0] div_rem;
   logic [31:0] div_quo;
   logic [63:0] prod_fix;
   logic [31:0] fix_hi;
   logic [31:0] fix_lo;

   function automatic logic [31:0] magnitude(input logic signed [31:0] v,
                                             input logic is_signed);
      if (is_signed && (v < 0)) return -v;
      else return v;
   endfunction

   function automatic logic [31:0] apply_sign32(input logic [31:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [63:0] apply_sign64(input logic [63:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   // Request decode; a new op is only taken in IDLE without a flush.
   always_comb begin
      is_mul    = (bus.MDUCode == MDU_MULT) || (bus.MDUCode == MDU_MULTU);
      is_div    = (bus.MDUCode == MDU_DIV)  || (bus.MDUCode == MDU_DIVU);
      is_md     = is_mul || is_div;
      signed_op = (bus.MDUCode == MDU_MULT) || (bus.MDUCode == MDU_DIV);
      load      = (state == IDLE) && bus.start && !bus.flush && is_md;
   end

`ifdef MDU_FAST_MUL_EN
   logic [63:0] fast_prod;
   // Sign- or zero-extend to 64 bits so one multiplier serves MULT and MULTU.
   always_comb begin
      fast_prod = {{32{signed_op & bus.A[31]}}, bus.A} *
                  {{32{signed_op & bus.B[31]}}, bus.B};
   end
`endif

   mdu_div_step u_div_step (
      .rem      (acc_hi),
      .quo      (acc_lo),
      .divisor  (opnd_b),
      .rem_next (div_rem),
      .quo_next (div_quo)
   );

   // Multiply step and final sign correction of the magnitude results.
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : 33'd0);
      prod_fix = apply_sign64({acc_hi, acc_lo}, neg_prod);
      if (op_div) begin
         fix_hi = apply_sign32(acc_hi, neg_rem);
         fix_lo = div0 ? DIV0_LO : apply_sign32(acc_lo, neg_quo);
      end else begin
         fix_hi = prod_fix[63:32];
         fix_lo = prod_fix[31:0];
      end
   end

   // Operand capture and per-cycle iteration; the datapath needs no reset
   // because every op reloads it before use.
   always_ff @(posedge clk) begin
      if (load) begin
         acc_hi   <= '0;
         acc_lo   <= magnitude(bus.A, signed_op);
         opnd_b   <= magnitude(bus.B, signed_op);
         op_div   <= is_div;
         neg_prod <= signed_op & (bus.A[31] ^ bus.B[31]);
         neg_quo  <= signed_op & (bus.A[31] ^ bus.B[31]);
         neg_rem  <= signed_op & bus.A[31];
         div0     <= (bus.B == 32'd0);
      end else if (state == RUN) begin
         if (op_div) begin
            acc_hi <= div_rem;
            acc_lo <= div_quo;
         end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
         end
      end
   end

   // Control FSM with registered busy and the architectural HI/LO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else if (bus.flush) begin
         // Squash wins over start in IDLE and over writeback in FIX.
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.MDUCode == MDU_MTHI) begin
                     hi <= bus.A;
                  end else if (bus.MDUCode == MDU_MTLO) begin
                     lo <= bus.A;
`ifdef MDU_FAST_MUL_EN
                  end else if (is_mul) begin
                     {hi, lo} <= fast_prod;
`endif
                  end else if (is_md) begin
                     state <= RUN;
                     cnt   <= 6'(ITER);
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               cnt <= cnt - 6'd1;
               if (cnt == 6'd1) state <= FIX;
            end
            FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy;
   assign bus.HI   = hi;
   assign bus.LO   = lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: hand-computed HI/LO results, busy-cycle
// counts, flush, start-while-busy and asynchronous reset behaviour.
// Under MDU_FAST_MUL_EN the expected multiply latency becomes zero.
module tb_mdu_hilo;
   import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 0;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   int   ncyc;

   mdu_hilo_if bus ();

   mdu_hilo #(
      .ITER    (32),
      .DIV0_LO (32'hFFFF_FFFF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: present one request for a single rising edge.
   task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
      bus.start   = 1'b1;
      bus.MDUCode = code;
      bus.A       = a;
      bus.B       = b;
      @(negedge clk);
      bus.start   = 1'b0;
   endtask

   // Count busy cycles sampled at negedges, bounded so the bench cannot hang.
   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] code,
                         input logic [31:0] a, input logic [31:0] b, input int lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      issue(code, a, b);
      wait_idle(n);
      check({tag, "_cycles"}, n, lat);
      check({tag, "_hi"}, bus.HI, exp_hi);
      check({tag, "_lo"}, bus.LO, exp_lo);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.flush   = 1'b0;
      bus.MDUCode = MDU_MULT;
      bus.A       = '0;
      bus.B       = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_hi", bus.HI, 32'd0);
      check("rst_lo", bus.LO, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Arithmetic results
      run_op("mult_neg3x5", MDU_MULT, 32'hFFFF_FFFD, 32'd5, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_neg7by2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_100by7", MDU_DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);
      run_op("divu_by0", MDU_DIVU, 32'h0000_1234, 32'd0, DIV_LAT, 32'h0000_1234, 32'hFFFF_FFFF);
      run_op("div_by0_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd0, DIV_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run_op("div_min_by_m1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'd0, 32'h8000_0000);

      // Moves to HI/LO take effect in one edge without busy
      issue(MDU_MTHI, 32'hAAAA_5555, 32'd0);
      check("mthi_busy", {31'd0, bus.busy}, 32'd0);
      check("mthi_hi", bus.HI, 32'hAAAA_5555);
      issue(MDU_MTLO, 32'h5A5A_5A5A, 32'd0);
      check("mtlo_busy", {31'd0, bus.busy}, 32'd0);
      check("mtlo_lo", bus.LO, 32'h5A5A_5A5A);
      check("mtlo_hi_kept", bus.HI, 32'hAAAA_5555);

      // Unused code 6 is ignored
      issue(3'd6, 32'h1234_5678, 32'd3);
      check("code6_busy", {31'd0, bus.busy}, 32'd0);
      check("code6_hi", bus.HI, 32'hAAAA_5555);
      check("code6_lo", bus.LO, 32'h5A5A_5A5A);

      // Flush together with start in IDLE blocks the request
      bus.flush = 1'b1;
      issue(MDU_MULT, 32'd2, 32'd3);
      bus.flush = 1'b0;
      check("flush_start_busy", {31'd0, bus.busy}, 32'd0);
      check("flush_start_hi", bus.HI, 32'hAAAA_5555);
      check("flush_start_lo", bus.LO, 32'h5A5A_5A5A);

      // Flush in flight at busy cycle 10
`ifdef MDU_FAST_MUL_EN
      issue(MDU_DIVU, 32'd6, 32'd7);
`else
      issue(MDU_MULT, 32'd6, 32'd7);
`endif
      repeat (9) @(negedge clk);
      check("flush_mid_busy_before", {31'd0, bus.busy}, 32'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_mid_busy_after", {31'd0, bus.busy}, 32'd0);
      check("flush_mid_hi", bus.HI, 32'hAAAA_5555);
      check("flush_mid_lo", bus.LO, 32'h5A5A_5A5A);

      // Start while busy (an MTHI) must be ignored
      issue(MDU_DIVU, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      issue(MDU_MTHI, 32'hDEAD_0000, 32'd0);
      wait_idle(ncyc);
      check("busy_start_cycles", ncyc, 32'(DIV_LAT - 4));
      check("busy_start_hi", bus.HI, 32'd2);
      check("busy_start_lo", bus.LO, 32'd14);

      // Asynchronous reset in the middle of a divide
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_hi", bus.HI, 32'd0);
      check("midrst_lo", bus.LO, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("mult_6x7", MDU_MULT, 32'd6, 32'd7, MUL_LAT, 32'd0, 32'd42);

      // Flush in the FIX cycle suppresses writeback
      issue(MDU_DIVU, 32'd100, 32'd7);
      repeat (32) @(negedge clk);
      check("fixflush_busy_before", {31'd0, bus.busy}, 32'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("fixflush_busy_after", {31'd0, bus.busy}, 32'd0);
      check("fixflush_hi", bus.HI, 32'd0);
      check("fixflush_lo", bus.LO, 32'd42);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
